// File: rtl/div_seq_param.sv
// div_seq_param: multi-cycle restoring divider (lo = a / b, hi = a % b).
// One quotient bit per CALC cycle, then a FIX cycle for sign correction and a
// DONE cycle; done is a registered one-cycle pulse after leaving DONE.
// Optional feature macro: DIV_SIGNED_EN (honour is_signed; signed DIV/DIVU).
module div_seq_param #(
  parameter int W     = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         init,
  input  logic         stop,
  input  logic         is_signed,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         divzero
);

`ifdef DIV_SIGNED_EN
  localparam logic SIGNED_EN = 1'b1;
`else
  localparam logic SIGNED_EN = 1'b0;
`endif

  localparam logic [W-1:0] ONE_W = W'(1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]   r_q, r_d;      // partial remainder
  logic [W-1:0]   q_q, q_d;      // quotient being built
  logic [W-1:0]   qa_q, qa_d;    // dividend magnitude, shifted out MSB first
  logic [W-1:0]   dv_q, dv_d;    // divisor magnitude
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           negq_q, negq_d;
  logic           negr_q, negr_d;
  logic           done_q, done_d;
  logic           divzero_q, divzero_d;

  logic           a_neg, b_neg;
  logic [W-1:0]   a_mag, b_mag;
  logic [W:0]     r_sh;
  logic           ge;

  function automatic logic [W-1:0] neg2(input logic [W-1:0] v);
    return (~v) + ONE_W;
  endfunction

  // State and datapath registers, async active-high clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      r_q       <= '0;
      q_q       <= '0;
      qa_q      <= '0;
      dv_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      r_q       <= r_d;
      q_q       <= q_d;
      qa_q      <= qa_d;
      dv_q      <= dv_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

  // Next-state and datapath: accept, iterate, sign-fix, report
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    r_d       = r_q;
    q_d       = q_q;
    qa_d      = qa_q;
    dv_d      = dv_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    divzero_d = divzero_q;
    done_d    = 1'b0;

    a_neg = SIGNED_EN & is_signed & a[W-1];
    b_neg = SIGNED_EN & is_signed & b[W-1];
    a_mag = a_neg ? neg2(a) : a;
    b_mag = b_neg ? neg2(b) : b;

    // Dividend is shifted left instead of indexed by the counter; the
    // extra top bit keeps the compare exact for divisors above 2**(W-1).
    r_sh = {r_q, qa_q[W-1]};
    ge   = (r_sh >= {1'b0, dv_q});

    if (stop) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (init) begin
            if (b == '0) begin
              divzero_d = 1'b1;
              hi_d      = '0;
              lo_d      = '0;
              state_d   = S_DONE;
            end else begin
              divzero_d = 1'b0;
              qa_d      = a_mag;
              dv_d      = b_mag;
              negq_d    = a_neg ^ b_neg;
              negr_d    = a_neg;
              cnt_d     = CNT_W'(W);
              r_d       = '0;
              q_d       = '0;
              state_d   = S_CALC;
            end
          end
        end
        S_CALC: begin
          r_d   = ge ? (r_sh[W-1:0] - dv_q) : r_sh[W-1:0];
          q_d   = {q_q[W-2:0], ge};
          qa_d  = {qa_q[W-2:0], 1'b0};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_FIX;
        end
        S_FIX: begin
          lo_d    = negq_q ? neg2(q_q) : q_q;
          hi_d    = negr_q ? neg2(r_q) : r_q;
          state_d = S_DONE;
        end
        S_DONE: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign busy    = (state_q == S_CALC) || (state_q == S_FIX);
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign divzero = divzero_q;

endmodule

// File: tb/tb_div_seq_param.sv
// Testbench for div_seq_param (W=32): table of operations with a result
// scoreboard, plus hand-written overlap, abort and async-reset sequences.
module tb_div_seq_param;

  localparam int W = 32;
`ifdef DIV_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         init = 1'b0;
  logic         stop = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, divzero;
  logic [W-1:0] hi, lo;

  div_seq_param #(.W(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .init(init), .stop(stop), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo), .divzero(divzero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b;
    logic         s;
    logic [W-1:0] hi, lo;
    logic         dz;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi, lo;
    logic         dz;
  } exp_t;

  vec_t tab[14];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_done = 0;

  function automatic vec_t mk(input logic [W-1:0] va, input logic [W-1:0] vb,
                              input logic vs, input logic [W-1:0] eh,
                              input logic [W-1:0] el, input logic ed);
    vec_t v;
    v.a = va; v.b = vb; v.s = vs; v.hi = eh; v.lo = el; v.dz = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: compare hi/lo/divzero on every done pulse
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      exp_t e;
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_hi", hi, e.hi);
        check("sb_lo", lo, e.lo);
        check("sb_divzero", {31'd0, divzero}, {31'd0, e.dz});
      end
    end
  end

  // Called at a negedge; returns #1 after the accepting edge
  task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs);
    a = va; b = vb; is_signed = vs; init = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    a = $urandom; b = $urandom; is_signed = 1'($urandom_range(0, 1));
  endtask

  // Counts edges since acceptance until done is seen; then checks pulse width
  task automatic wait_done(input string name, input int exp_lat, input int elapsed);
    int k;
    bit got;
    k = elapsed;
    got = 1'b0;
    while (k < 80 && !got) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      if (done === 1'b1) got = 1'b1;
    end
    check({name, "_latency"}, got ? 32'(k) : 32'hFFFF_FFFF, 32'(exp_lat));
    if (got) begin
      @(posedge clk);
      @(negedge clk);
      check({name, "_done_pulse"}, {31'd0, done}, 32'd0);
    end
  endtask

  task automatic run_op(input vec_t v, input string name);
    exp_t e;
    e.hi = v.hi; e.lo = v.lo; e.dz = v.dz;
    sb.push_back(e);
    issue(v.a, v.b, v.s);
    @(negedge clk);
    check({name, "_busy"}, {31'd0, busy}, {31'd0, (v.b != '0)});
    wait_done(name, (v.b == '0) ? 1 : W + 2, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    tab[0]  = mk(32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b0);
    tab[1]  = mk(32'hFFFF_FFF9, 32'd2, 1'b1,
                 SGN ? 32'hFFFF_FFFF : 32'd1, SGN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC, 1'b0);
    tab[2]  = mk(32'd5, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
    tab[3]  = mk(32'd9, 32'd3, 1'b0, 32'd0, 32'd3, 1'b0);
    tab[4]  = mk(32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
                 SGN ? 32'd0 : 32'h8000_0000, SGN ? 32'h8000_0000 : 32'd0, 1'b0);
    tab[5]  = mk(32'd7, 32'hFFFF_FFFE, 1'b1,
                 SGN ? 32'd1 : 32'd7, SGN ? 32'hFFFF_FFFD : 32'd0, 1'b0);
    tab[6]  = mk(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1,
                 SGN ? 32'hFFFF_FFFF : 32'hFFFF_FFF9, SGN ? 32'd3 : 32'd0, 1'b0);
    tab[7]  = mk(32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0);
    tab[8]  = mk(32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 32'hFFFF_FFFF, 1'b0);
    tab[9]  = mk(32'd12345678, 32'd1000, 1'b0, 32'd678, 32'd12345, 1'b0);
    tab[10] = mk(32'hDEAD_BEEF, 32'h10, 1'b0, 32'hF, 32'h0DEA_DBEE, 1'b0);
    tab[11] = mk(32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0);
    tab[12] = mk(32'hFFFF_FF9C, 32'd7, 1'b1,
                 SGN ? 32'hFFFF_FFFE : 32'd2, SGN ? 32'hFFFF_FFF2 : 32'h2492_4916, 1'b0);
    tab[13] = mk(32'hFFFF_FF9C, 32'd0, 1'b1, 32'd0, 32'd0, 1'b1);

    // Reset state
    #1 rst = 1'b1;
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_divzero", {31'd0, divzero}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) run_op(tab[i], $sformatf("vec%0d", i));

    // Overlapping init during CALC is ignored
    begin
      exp_t e;
      e.hi = 32'd2; e.lo = 32'd14; e.dz = 1'b0;
      sb.push_back(e);
      issue(32'd100, 32'd7, 1'b0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      a = 32'd1; b = 32'd1; init = 1'b1;
      @(posedge clk);
      #1 init = 1'b0;
      wait_done("overlap", W + 2, 5);
    end

    // Abort mid-CALC: no done, results held
    run_op(tab[0], "pre_abort");
    d0 = n_done;
    issue(32'd1000, 32'd3, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd2);
    check("abort_lo", lo, 32'd14);
    repeat (40) @(negedge clk);
    check("abort_no_done", 32'(n_done - d0), 32'd0);

    // init together with stop is dropped
    a = 32'd50; b = 32'd5; init = 1'b1; stop = 1'b1;
    @(posedge clk);
    #1 begin init = 1'b0; stop = 1'b0; end
    @(negedge clk);
    check("initstop_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    check("initstop_no_done", 32'(n_done - d0), 32'd0);
    check("initstop_lo", lo, 32'd14);

    // divzero holds across an abort, cleared by next accepted init
    run_op(tab[2], "dz_again");
    issue(32'd1000, 32'd3, 1'b0);
    @(negedge clk);
    check("dz_cleared_on_accept", {31'd0, divzero}, 32'd0);
    stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    @(negedge clk);

    // Async reset mid-CALC clears outputs before the next edge
    issue(32'd1000, 32'd3, 1'b0);
    repeat (8) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("amid_busy", {31'd0, busy}, 32'd0);
    check("amid_done", {31'd0, done}, 32'd0);
    check("amid_hi", hi, 32'd0);
    check("amid_lo", lo, 32'd0);
    check("amid_divzero", {31'd0, divzero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(tab[3], "post_reset");

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
